softcore_dmem_ctrl: RTL and testbench
=====================================

// Module: softcore_dmem_ctrl
// PURPOSE
//   Data-memory controller directly downstream of the tflite_softcore load/store port.
//   Consumes the core's address/write_data/we/re and returns read_data plus a one-cycle ready pulse.
//   Backs a word-addressed on-chip RAM and inserts configurable wait states.
//   Flags misaligned, out-of-range and conflicting requests via err.
// PARAMETERS
//   DATA_WIDTH   32             data word width (bits)
//   DEPTH_WORDS  1024           RAM depth in words
//   BASE_ADDR    32'h0000_1000  byte address of word 0
//   WAIT_STATES  2              extra cycles between accept and RAM access (0..15)
// PORTS
//   clk         in   1   single clock; all logic on rising edge
//   rst         in   1   synchronous reset, active-high
//   address     in   32  byte address from core
//   write_data  in   32  store data from core
//   we          in   1   store request (level, held by core until ready)
//   re          in   1   load request (level, held by core until ready)
//   read_data   out  32  load result; valid in the ready cycle, held until next load response
//   ready       out  1   one-cycle completion pulse
//   busy        out  1   high from the cycle after accept through the ready cycle
//   err         out  1   qualifies ready: request rejected, no RAM access
// BEHAVIOUR
//   Reset: state=IDLE, ready=0, busy=0, err=0, read_data=0, wait counter=0. RAM contents not cleared.
//   FSM states: IDLE, WAIT, ACCESS, RESP.
//   IDLE: if (we|re), latch address/write_data/we/re on this edge (the accept cycle t).
//     Valid request -> WAIT (WAIT_STATES>0) or ACCESS (WAIT_STATES==0).
//     Invalid request -> RESP with err=1.
//   Invalid request: we&re both high, address[1:0]!=0, address<BASE_ADDR,
//     or ((address-BASE_ADDR)>>2) >= DEPTH_WORDS.
//   WAIT: counter counts WAIT_STATES cycles, then -> ACCESS.
//   ACCESS: word index = (latched_addr-BASE_ADDR)>>2.
//     Store: write RAM[index].
//     Load: read RAM[index] into read_data. -> RESP.
//   RESP: ready=1 for exactly one cycle. err is valid with it. -> IDLE.
//   Latency (accept edge t to the ready cycle):
//     Valid request: WAIT_STATES+2 cycles.
//     Invalid request: 1 cycle.
//   Inputs are sampled only in IDLE. Changes while busy are ignored.
//   A request still held in the cycle after RESP is accepted again as a new request.
//     The core must drop we/re on the edge where it sees ready.
//   Rejected load: read_data=0 in its ready cycle. Store: read_data unchanged.
//   err is cleared on the next accept. ready and err are never high outside RESP.
//   Reset mid-operation: abort immediately, return to IDLE, no pulse.
//     A store aborted before its ACCESS edge leaves RAM unchanged.
//   No queueing: at most one outstanding request.
//   Highest valid address = BASE_ADDR + 4*DEPTH_WORDS - 4.
// TESTING  (defaults unless stated)
//   1. rst=1 for 2 cycles with we=re=1
//      -> ready=0, busy=0, err=0, read_data=0; no accept until rst=0.
//   2. Store 32'hDEADBEEF @0x1004, then load @0x1004
//      -> read_data=32'hDEADBEEF; ready exactly 4 cycles after each accept; ready high 1 cycle.
//   3. Load @0x1002 (misaligned)
//      -> ready at t+1 with err=1, read_data=0; RAM untouched.
//   4. Store 32'h5 @0x2000 -> err=1.
//      Store/load 32'hA5A5A5A5 @0x1FFC (last word) -> err=0, read back 32'hA5A5A5A5.
//   5. we=re=1 @0x1008 -> err=1, ready at t+1.
//      Then store 32'h11 @0x1008; pulse rst during WAIT of a store of 32'h22 @0x1008;
//      load @0x1008 -> 32'h11.
//   6. Build with WAIT_STATES=0: back-to-back loads held across ready
//      -> ready every 3 cycles, busy low only in the IDLE cycles between them.

Source files
------------

// File: rtl/softcore_dmem_ctrl.sv
// softcore_dmem_ctrl
//   Data-memory controller that sits behind the softcore load/store port.
//   It accepts one load or store at a time and services it from a word-addressed
//   on-chip RAM after WAIT_STATES extra cycles. It then returns a one-cycle ready
//   pulse. Misaligned, out-of-range and conflicting (we & re) requests do not
//   touch the RAM. They complete one cycle after accept with err set.
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst         synchronous reset, active-high
//   address     byte address from the core
//   write_data  store data from the core
//   we / re     store / load request levels, held by the core until ready
//   read_data   load result; holds its value until the next load response
//   ready       one-cycle completion pulse
//   busy        high from the cycle after accept through the ready cycle
//   err         qualifies ready: the request was rejected
//
// State table
//   state  | meaning
//   IDLE   | waiting for we|re; latches the request when it is seen
//   WAIT   | counting down the configured wait states
//   ACCESS | single RAM write (store) or read into read_data (load)
//   RESP   | ready pulse, with err if the request was rejected
module softcore_dmem_ctrl #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  ready,
  output logic                  busy,
  output logic                  err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // The down-counter is loaded with WAIT_STATES-1 so that the terminal-count
  // compare against zero gives exactly WAIT_STATES cycles in WAIT.
  localparam int          WAIT_LOAD_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0]  WAIT_LOAD   = 4'(WAIT_LOAD_I);
  localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic                  err_q;
  logic                  we_q;
  logic [AW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [31:0] req_offset;
  logic [31:0] req_word;
  logic        req_bad;

  assign req_offset = address - BASE_ADDR;
  assign req_word   = req_offset >> 2;

  // An address below the base wraps to a huge offset. It is still tested
  // explicitly so the rule does not depend on that wrap.
  assign req_bad = (we & re)
                 | (address[1:0] != 2'b00)
                 | (address < BASE_ADDR)
                 | (req_word >= DEPTH_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      read_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (we | re) begin
            idx_q    <= req_word[AW-1:0];
            wdata_q  <= write_data;
            we_q     <= we;
            err_q    <= req_bad;
            wait_cnt <= WAIT_LOAD;
            if (req_bad) begin
              // A rejected request that asked for a load, including we&re,
              // returns zero. A rejected pure store leaves read_data alone.
              if (re) read_data <= '0;
              state <= S_RESP;
            end else if (WAIT_STATES == 0) begin
              state <= S_ACCESS;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_ACCESS;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        S_ACCESS: begin
          if (!we_q) read_data <= mem[idx_q];
          state <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The RAM has no reset. A store is committed only on its ACCESS edge, and
  // that edge is also gated by rst, so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (!rst && state == S_ACCESS && we_q) mem[idx_q] <= wdata_q;
  end

  assign ready = (state == S_RESP);
  assign busy  = (state != S_IDLE);
  assign err   = ready & err_q;

endmodule

// File: tb/tb_softcore_dmem_ctrl.sv
module tb_softcore_dmem_ctrl;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 1024;
  localparam int          WS    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, write_data, read_data;
  logic        we, re, ready, busy, err;

  logic [31:0] a2, wd2, rd2;
  logic        we2, re2, rdy2, busy2, err2;

  always #5 clk = ~clk;

  softcore_dmem_ctrl #(.DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data), .we(we), .re(re),
    .read_data(read_data), .ready(ready), .busy(busy), .err(err)
  );

  softcore_dmem_ctrl #(.DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst(rst), .address(a2), .write_data(wd2), .we(we2), .re(re2),
    .read_data(rd2), .ready(rdy2), .busy(busy2), .err(err2)
  );

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  logic [31:0] model_mem [int];
  logic [31:0] model_rd   = 32'h0;
  int          written[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: the request is classified straight from the address rules.
  // The result is queued together with the cycle of its accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    exp_t        e;
    bit          bad;
    int unsigned widx;
    int          n;
    widx = (a - BASE) / 4;
    bad  = (w && r) || (a % 4 != 0) || (a < BASE) || (widx >= DEPTH);
    if (bad) begin
      if (r) model_rd = 32'h0;
    end else if (w) begin
      model_mem[int'(widx)] = d;
      written.push_back(int'(widx));
    end else begin
      model_rd = model_mem[int'(widx)];
    end
    e.err  = bad;
    e.data = model_rd;
    e.acc  = cyc + 1;
    e.lat  = bad ? 1 : WS + 2;
    sb.push_back(e);
    address = a; write_data = d; we = w; re = r;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 40);
    if (!ready) begin
      compared++;
      mismatched++;
      $display("FAIL ready_timeout: got no ready after %0d cycles, expected ready at addr %h", n, a);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    we = 1'b0; re = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ready) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_ready: got ready=1 expected no pending request");
        end else begin
          mon_e = sb.pop_front();
          chk("err", {31'b0, err}, {31'b0, mon_e.err});
          chk("read_data", read_data, mon_e.data);
          chk("latency", cyc - mon_e.acc + 1, mon_e.lat);
          chk("busy_in_ready", {31'b0, busy}, 32'd1);
        end
      end else begin
        chk("err_outside_ready", {31'b0, err}, 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    int          k, idx, n;

    rst = 1'b1; address = 32'h1004; write_data = 32'h0; we = 1'b1; re = 1'b1;
    a2 = 32'h0; wd2 = 32'h0; we2 = 1'b0; re2 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", {31'b0, ready}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_read_data", read_data, 32'd0);
    end
    we = 1'b0; re = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);

    issue(32'h1004, 32'hDEADBEEF, 1'b1, 1'b0);
    issue(32'h1004, 32'h0, 1'b0, 1'b1);
    issue(32'h1002, 32'h0, 1'b0, 1'b1);
    issue(32'h1004, 32'h0, 1'b0, 1'b1);
    issue(32'h2000, 32'h5, 1'b1, 1'b0);
    issue(32'h1FFC, 32'hA5A5A5A5, 1'b1, 1'b0);
    issue(32'h1FFC, 32'h0, 1'b0, 1'b1);
    issue(32'h1008, 32'h0, 1'b1, 1'b1);
    issue(32'h1008, 32'h11, 1'b1, 1'b0);

    // Store of 0x22 aborted by reset while it is in WAIT.
    address = 32'h1008; write_data = 32'h22; we = 1'b1;
    @(negedge clk);
    chk("abort_busy_before_rst", {31'b0, busy}, 32'd1);
    rst = 1'b1; we = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_ready", {31'b0, ready}, 32'd0);
    chk("abort_read_data", read_data, 32'd0);
    model_rd = 32'h0;
    rst = 1'b0;
    @(negedge clk);
    issue(32'h1008, 32'h0, 1'b0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      if (k >= 4 && k <= 6 && written.size() == 0) k = 0;
      if (k <= 3) begin
        idx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(DEPTH - 16, DEPTH - 1);
        issue(BASE + 32'(4 * idx), $urandom, 1'b1, 1'b0);
      end else if (k <= 6) begin
        idx = written[$urandom_range(0, written.size() - 1)];
        issue(BASE + 32'(4 * idx), 32'h0, 1'b0, 1'b1);
      end else if (k == 7) begin
        a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        n = $urandom_range(0, 1);
        issue(a, $urandom, n[0], ~n[0]);
      end else if (k == 8) begin
        if ($urandom_range(0, 1) == 0) a = BASE - 32'(4 * $urandom_range(1, 64));
        else                           a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 64));
        n = $urandom_range(0, 1);
        issue(a, $urandom, n[0], ~n[0]);
      end else begin
        issue(BASE + 32'(4 * $urandom_range(0, 15)), $urandom, 1'b1, 1'b1);
      end
    end

    // Zero-wait-state build: store, then a load held across several responses.
    d = 32'hCAFEF00D;
    a2 = 32'h1010; wd2 = d; we2 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy2 && n < 20);
    chk("ws0_store_ready", {31'b0, rdy2}, 32'd1);
    chk("ws0_store_latency", n, 2);
    chk("ws0_store_err", {31'b0, err2}, 32'd0);
    we2 = 1'b0; re2 = 1'b1;
    for (int p = 1; p <= 15; p++) begin
      @(negedge clk);
      if (p % 3 == 1) begin
        chk("ws0_idle_busy", {31'b0, busy2}, 32'd0);
        chk("ws0_idle_ready", {31'b0, rdy2}, 32'd0);
      end else if (p % 3 == 2) begin
        chk("ws0_access_busy", {31'b0, busy2}, 32'd1);
        chk("ws0_access_ready", {31'b0, rdy2}, 32'd0);
      end else begin
        chk("ws0_resp_ready", {31'b0, rdy2}, 32'd1);
        chk("ws0_resp_busy", {31'b0, busy2}, 32'd1);
        chk("ws0_resp_data", rd2, d);
        chk("ws0_resp_err", {31'b0, err2}, 32'd0);
      end
    end
    re2 = 1'b0;

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
